// File: rtl/md_pkg.sv
// Shared particle-pair definitions: stored pair width, null-flag position and
// the field layout of a neighbour pair as produced by the particle filter.
package md_pkg;

  localparam int PAIR_W   = 226;
  localparam int NULL_BIT = 226;

  localparam int CELL_W = 8;
  localparam int ID_W   = 9;
  localparam int POS_W  = 96;

  localparam int NBR_POS_LSB  = 0;
  localparam int NBR_ID_LSB   = NBR_POS_LSB + POS_W;
  localparam int NBR_CELL_LSB = NBR_ID_LSB + ID_W;
  localparam int REF_POS_LSB  = NBR_CELL_LSB + CELL_W;
  localparam int REF_ID_LSB   = REF_POS_LSB + POS_W;
  localparam int REF_CELL_LSB = REF_ID_LSB + ID_W;

  // Field order matches the stored bit layout, most significant field first.
  typedef struct packed {
    logic [CELL_W-1:0] ref_cell;
    logic [ID_W-1:0]   ref_id;
    logic [POS_W-1:0]  ref_pos;
    logic [CELL_W-1:0] nbr_cell;
    logic [ID_W-1:0]   nbr_id;
    logic [POS_W-1:0]  nbr_pos;
  } pair_t;

endpackage

// File: rtl/pair_fifo_ram.sv
// Pair storage for pair_queue: one synchronous write port and an asynchronous
// read port so the head entry falls through without an output register.
module pair_fifo_ram
  import md_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              fast_clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [PAIR_W-1:0] rd_data
);

  logic [PAIR_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the queue count.
  always_ff @(posedge fast_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pair_queue.sv
// First-word fall-through queue between the particle filter and force pipeline.
// Define PAIR_QUEUE_STATS_EN to add the saturating drop_count port and counter.
module pair_queue
  import md_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                    fast_clk,
  input  logic                    reset,
  input  logic [PAIR_W:0]         in_pair,
  input  logic                    flush,
  output logic [PAIR_W-1:0]       out_pair,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
`ifdef PAIR_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0]        drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          is_null, push, pop, drop;
`ifdef PAIR_QUEUE_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
`ifdef PAIR_QUEUE_STATS_EN
  assign drop_count = drop_cnt_q;
`endif

  // A full queue still accepts a pair when the head leaves on the same edge.
  always_comb begin
    is_null    = in_pair[NULL_BIT];
    pop        = out_valid && out_ready;
    push       = !is_null && (!full || pop);
    drop       = !is_null && full && !pop;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
`ifdef PAIR_QUEUE_STATS_EN
    drop_cnt_d = drop_cnt_q;
`endif
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
`ifdef PAIR_QUEUE_STATS_EN
      drop_cnt_d = '0;
`endif
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
      overflow_d = overflow_q | drop;
`ifdef PAIR_QUEUE_STATS_EN
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef PAIR_QUEUE_STATS_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef PAIR_QUEUE_STATS_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  pair_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .fast_clk (fast_clk),
    .wr_en    (push && !flush),
    .wr_addr  (wptr_q),
    .wr_data  (in_pair[PAIR_W-1:0]),
    .rd_addr  (rptr_q),
    .rd_data  (out_pair)
  );

endmodule

// File: tb/tb_pair_queue.sv
// Directed bench for pair_queue: a vector table for push/pop ordering and null
// filtering, then hand sequences for overflow, flush, async reset and saturation.
module tb_pair_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;

  logic         fast_clk = 1'b0;
  logic         reset    = 1'b0;
  logic [226:0] in_pair  = '0;
  logic         flush    = 1'b0;
  logic         out_ready = 1'b0;
  logic [225:0] out_pair;
  logic         out_valid;
  logic [4:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
`ifdef PAIR_QUEUE_STATS_EN
  logic [CNT_W-1:0] drop_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic       nul;
    logic [8:0] id;
    logic       rdy;
    int         exp_count;
    logic       exp_valid;
    logic [8:0] exp_head;
  } vec_t;

  vec_t vecs [21];

  always #5 fast_clk = ~fast_clk;

  pair_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .fast_clk   (fast_clk),
    .reset      (reset),
    .in_pair    (in_pair),
    .flush      (flush),
    .out_pair   (out_pair),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
`ifdef PAIR_QUEUE_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  // Distinct, id-derived content in every field so misplaced bits are caught.
  function automatic logic [225:0] pair_body(input logic [8:0] id);
    return {8'hA5, id, 87'd0, id, 8'h5A, ~id, 87'd0, id};
  endfunction

  task automatic applyStimulus(input logic nul, input logic [8:0] id,
                               input logic rdy, input logic fl);
    in_pair   = {nul, pair_body(id)};
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkHead(input string name, input logic [8:0] exp_id);
    logic [225:0] exp_pair;
    exp_pair = pair_body(exp_id);
    n_checks++;
    if (out_pair !== exp_pair) begin
      n_fails++;
      $display("[TB] FAIL %s: head ref id got %0d (pair %h), expected %0d",
               name, out_pair[217:209], out_pair, exp_id);
    end
  endtask

  task automatic checkStatus(input string name, input int exp_count,
                             input logic exp_ovf);
    checkOutput({name, ".count"}, 32'(count), 32'(exp_count));
    checkOutput({name, ".valid"}, 32'(out_valid), 32'(exp_count != 0));
    checkOutput({name, ".empty"}, 32'(empty), 32'(exp_count == 0));
    checkOutput({name, ".full"}, 32'(full), 32'(exp_count == DEPTH));
    checkOutput({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 9'd1,  1'b0, 1, 1'b1, 9'd1};
    vecs[1]  = '{1'b0, 9'd2,  1'b0, 2, 1'b1, 9'd1};
    vecs[2]  = '{1'b0, 9'd3,  1'b0, 3, 1'b1, 9'd1};
    vecs[3]  = '{1'b1, 9'd0,  1'b1, 2, 1'b1, 9'd2};
    vecs[4]  = '{1'b1, 9'd0,  1'b1, 1, 1'b1, 9'd3};
    vecs[5]  = '{1'b1, 9'd0,  1'b1, 0, 1'b0, 9'd0};
    vecs[6]  = '{1'b1, 9'd10, 1'b0, 0, 1'b0, 9'd0};
    vecs[7]  = '{1'b0, 9'd11, 1'b0, 1, 1'b1, 9'd11};
    vecs[8]  = '{1'b1, 9'd12, 1'b0, 1, 1'b1, 9'd11};
    vecs[9]  = '{1'b0, 9'd13, 1'b0, 2, 1'b1, 9'd11};
    vecs[10] = '{1'b1, 9'd14, 1'b0, 2, 1'b1, 9'd11};
    vecs[11] = '{1'b0, 9'd15, 1'b0, 3, 1'b1, 9'd11};
    vecs[12] = '{1'b1, 9'd16, 1'b0, 3, 1'b1, 9'd11};
    vecs[13] = '{1'b0, 9'd17, 1'b0, 4, 1'b1, 9'd11};
    vecs[14] = '{1'b1, 9'd0,  1'b1, 3, 1'b1, 9'd13};
    vecs[15] = '{1'b1, 9'd0,  1'b1, 2, 1'b1, 9'd15};
    vecs[16] = '{1'b1, 9'd0,  1'b1, 1, 1'b1, 9'd17};
    vecs[17] = '{1'b1, 9'd0,  1'b1, 0, 1'b0, 9'd0};
    vecs[18] = '{1'b0, 9'd20, 1'b0, 1, 1'b1, 9'd20};
    vecs[19] = '{1'b0, 9'd21, 1'b1, 1, 1'b1, 9'd21};
    vecs[20] = '{1'b1, 9'd0,  1'b1, 0, 1'b0, 9'd0};

    applyStimulus(1'b1, 9'd0, 1'b0, 1'b0);
    #12;
    checkStatus("reset", 0, 1'b0);
`ifdef PAIR_QUEUE_STATS_EN
    checkOutput("reset.drop_count", 32'(drop_count), 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].nul, vecs[i].id, vecs[i].rdy, 1'b0);
      tick();
      checkStatus($sformatf("vec%0d", i), vecs[i].exp_count, 1'b0);
      if (vecs[i].exp_valid) checkHead($sformatf("vec%0d.head", i), vecs[i].exp_head);
    end

    // Fill past capacity with the consumer stalled: the last two pairs are dropped.
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(1'b0, 9'(i), 1'b0, 1'b0);
      tick();
      if (i == 16) checkStatus("fill16", 16, 1'b0);
    end
    checkStatus("overfill", 16, 1'b1);
    checkHead("overfill.head", 9'd1);
`ifdef PAIR_QUEUE_STATS_EN
    checkOutput("overfill.drop_count", 32'(drop_count), 32'd2);
`endif

    applyStimulus(1'b0, 9'd50, 1'b1, 1'b0);
    tick();
    checkStatus("full_pushpop", 16, 1'b1);
    checkHead("full_pushpop.head", 9'd2);
`ifdef PAIR_QUEUE_STATS_EN
    checkOutput("full_pushpop.drop_count", 32'(drop_count), 32'd2);
`endif
    for (int k = 0; k < 16; k++) begin
      checkHead($sformatf("drain%0d", k), (k < 15) ? 9'(2 + k) : 9'd50);
      applyStimulus(1'b1, 9'd0, 1'b1, 1'b0);
      tick();
    end
    checkStatus("drained", 0, 1'b1);

    // Flush wins over a concurrent push and clears the sticky overflow.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 9'(30 + i), 1'b0, 1'b0);
      tick();
    end
    checkStatus("five", 5, 1'b1);
    applyStimulus(1'b0, 9'd99, 1'b0, 1'b1);
    tick();
    checkStatus("flush", 0, 1'b0);
`ifdef PAIR_QUEUE_STATS_EN
    checkOutput("flush.drop_count", 32'(drop_count), 32'd0);
`endif
    applyStimulus(1'b0, 9'd7, 1'b0, 1'b0);
    tick();
    checkStatus("post_flush", 1, 1'b0);
    checkHead("post_flush.head", 9'd7);
    applyStimulus(1'b1, 9'd0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset mid-burst must empty the queue before the next edge.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 9'(60 + i), 1'b0, 1'b0);
      tick();
    end
    checkStatus("burst7", 7, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst.valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst.count", 32'(count), 32'd0);
    checkOutput("async_rst.empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 9'd41, 1'b0, 1'b0);
    tick();
    checkStatus("in_reset", 0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 9'd42, 1'b0, 1'b0);
    tick();
    checkStatus("after_rst", 1, 1'b0);
    checkHead("after_rst.head", 9'd42);
    applyStimulus(1'b1, 9'd0, 1'b1, 1'b0);
    tick();
    checkStatus("after_rst.pop", 0, 1'b0);

`ifdef PAIR_QUEUE_STATS_EN
    // 2^CNT_W + 3 drops: the counter must stick at all-ones rather than wrap.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 9'(200 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      applyStimulus(1'b0, 9'(300 + i), 1'b0, 1'b0);
      tick();
    end
    checkStatus("saturate", 16, 1'b1);
    checkOutput("saturate.drop_count", 32'(drop_count), 32'((1 << CNT_W) - 1));
    checkHead("saturate.head", 9'd200);
`endif

    applyStimulus(1'b1, 9'd0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pair_queue.md
PAIR_QUEUE -- requirements
Module: pair_queue

Interface
REQ-001 Parameter DEPTH, default 16, meaning entries of pair storage; power of two, 4..256.
REQ-002 Parameter CNT_W, default 16, meaning drop-counter width.
REQ-003 fast_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_pair  input  227  particle-filter result: bit 226 null flag (1 = no pair); [225:218] ref cell; [217:209] ref id; [208:113] ref pos; [112:105] nbr cell; [104:96] nbr id; [95:0] nbr pos.
REQ-006 flush  input  1  synchronous clear of queue contents and status.
REQ-007 out_pair  output  226  head pair, the in_pair[225:0] layout.
REQ-008 out_valid  output  1  head entry present.
REQ-009 out_ready  input  1  force pipeline accepts the head.
REQ-010 count  output  log2(DEPTH)+1  occupied entries.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 overflow  output  1  sticky; a non-null pair was dropped.
REQ-014 drop_count  output  CNT_W  dropped non-null pairs (present only under PAIR_QUEUE_STATS_EN).

Function
REQ-015 Push condition: in_pair[226]==0 and (not full, or pop in the same cycle); in_pair[225:0] is written at the tail.
REQ-016 Null pairs (in_pair[226]==1) are never stored, counted or flagged.
REQ-017 Pop condition: out_valid && out_ready; the head advances on that edge.
REQ-018 First-word fall-through: out_pair is driven from the head entry without an extra register; out_valid = ~empty.
REQ-019 Latency: a pair pushed at edge N is visible on out_pair/out_valid after edge N when the queue was empty.
REQ-020 Simultaneous push and pop: count unchanged; legal when full and when holding a single entry.
REQ-021 Drop: non-null pair while full and no pop; the pair is discarded, overflow set, drop_count incremented.
REQ-022 drop_count saturates at all-ones; it does not wrap.
REQ-023 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately.
REQ-024 out_pair is don't-care while out_valid==0; the bench shall not check it.
REQ-025 Flush has priority over push and pop in the same cycle: pointers, count, overflow and drop_count cleared; the concurrent input is discarded.
REQ-026 out_valid must not depend combinationally on out_ready.

Reset
REQ-027 While reset==0: pointers 0, count 0, empty 1, full 0, out_valid 0, overflow 0, drop_count 0; storage contents are not reset.
REQ-028 Reset asserted mid-operation discards all entries immediately, asynchronously; the first push after release lands in entry 0.

Configuration
REQ-029 Macro PAIR_QUEUE_STATS_EN defined: drop_count port and its saturating counter exist.
REQ-030 Macro PAIR_QUEUE_STATS_EN undefined: no drop_count port or counter; overflow and all other behaviour identical.

Structure
REQ-031 The shared package md_pkg holds PAIR_W=226, NULL_BIT=226 and field offsets/widths: cell 8, id 9, pos 96.
REQ-032 The storage array is sub-module pair_fifo_ram: DEPTH x PAIR_W, one synchronous write port, asynchronous read at the head address.
REQ-033 Pointer, count and status logic resides in pair_queue.

Verification
REQ-034 Reset, then 3 non-null pairs with ids 1, 2, 3 and out_ready=0 -> count=3, out_pair ref id=1; raise out_ready for 3 cycles -> ids 1, 2, 3 pop in order, then empty=1.
REQ-035 Alternate null/non-null inputs for 8 cycles -> count=4; only non-null pairs stored.
REQ-036 DEPTH=16: push 18 non-null pairs, out_ready=0 -> full=1, overflow=1, drop_count=2, head is the first pair.
REQ-037 Full queue with in_pair non-null and out_ready=1 -> count stays 16, no drop, the new pair is at the tail.
REQ-038 Assert flush together with a push at count=5 -> count=0, empty=1, overflow=0; the push is discarded.
REQ-039 Assert reset asynchronously mid-burst at count=7 -> out_valid=0 and count=0 before the next edge; 2^CNT_W+3 drops -> drop_count holds all-ones.
